// File: rtl/game_pkg.sv
// Shared types and constants for the lab 3 board-game turn sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_MOVE,
        PLACE,
        CHECK,
        SWITCH,
        OVER
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    function automatic logic [1:0] winner_code(input logic player);
        return (player == P2) ? W_P2 : W_P1;
    endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Bundle between the turn controller and its surroundings (players, board, turn timer).
interface turn_controller_if #(
    parameter int NUM_COLS = 7,
    parameter int COL_W    = 3
);
    logic                start_game;
    logic                move_valid;
    logic [COL_W-1:0]    move_col;
    logic [NUM_COLS-1:0] col_full;
    logic                board_done;
    logic                win;
    logic                board_full;
    logic                time_out;

    logic                timer_start;
    logic                timer_clear;
    logic                place_valid;
    logic [COL_W-1:0]    place_col;
    logic                current_player;
    logic                move_reject;
    logic                game_over;
    logic [1:0]          winner;

    modport master (
        output start_game, move_valid, move_col, col_full,
               board_done, win, board_full, time_out,
        input  timer_start, timer_clear, place_valid, place_col,
               current_player, move_reject, game_over, winner
    );

    modport slave (
        input  start_game, move_valid, move_col, col_full,
               board_done, win, board_full, time_out,
        output timer_start, timer_clear, place_valid, place_col,
               current_player, move_reject, game_over, winner
    );
endinterface

// File: rtl/free_col_finder.sv
// Priority encoder: lowest-index column that is not full, plus an any-free flag.
module free_col_finder #(
    parameter int NUM_COLS = 7,
    parameter int COL_W    = 3
) (
    input  logic [NUM_COLS-1:0] col_full,
    output logic [COL_W-1:0]    free_idx,
    output logic                any_free
);

    // Scan downward so the lowest free column is the last one written.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!col_full[i]) begin
                free_idx = COL_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Two-player turn sequencer: drives the turn timer, arbitrates moves, declares the outcome.
// Optional build macro AUTO_MOVE_EN: on timeout, auto-place in the lowest free column.
module turn_controller
    import game_pkg::*;
#(
    parameter int NUM_COLS     = 7,
    parameter int COL_W        = 3,
    parameter int MAX_TIMEOUTS = 3
) (
    input logic               clk,
    input logic               rst,
    turn_controller_if.slave  bus
);

    localparam int TO_W = $clog2(MAX_TIMEOUTS + 1);

    state_t           state;
    logic [TO_W-1:0]  timeout_cnt;
    logic [TO_W-1:0]  cnt_inc;
    logic             move_legal;
    logic [COL_W-1:0] free_idx;
    logic             any_free;

    logic             timer_start;
    logic             timer_clear;
    logic             place_valid;
    logic [COL_W-1:0] place_col;
    logic             current_player;
    logic             move_reject;
    logic             game_over;
    logic [1:0]       winner;

    free_col_finder #(.NUM_COLS(NUM_COLS), .COL_W(COL_W)) u_free (
        .col_full (bus.col_full),
        .free_idx (free_idx),
        .any_free (any_free)
    );

`ifndef AUTO_MOVE_EN
    wire unused_free = ^{free_idx, any_free};
`endif

    // Out-of-range columns never match any index, so they are illegal.
    always_comb begin
        move_legal = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (bus.move_col == COL_W'(i) && !bus.col_full[i]) move_legal = 1'b1;
        end
    end

    assign cnt_inc = (timeout_cnt == TO_W'(MAX_TIMEOUTS)) ? timeout_cnt
                                                         : timeout_cnt + TO_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            timeout_cnt    <= '0;
            timer_start    <= 1'b0;
            timer_clear    <= 1'b1;
            place_valid    <= 1'b0;
            place_col      <= '0;
            current_player <= P1;
            move_reject    <= 1'b0;
            game_over      <= 1'b0;
            winner         <= W_NONE;
        end else begin
            move_reject <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (bus.start_game) begin
                        state          <= ARM;
                        current_player <= P1;
                        timeout_cnt    <= '0;
                        game_over      <= 1'b0;
                        winner         <= W_NONE;
                        timer_clear    <= 1'b1;
                        timer_start    <= 1'b0;
                    end
                end
                ARM: begin
                    state       <= WAIT_MOVE;
                    timer_clear <= 1'b0;
                    timer_start <= 1'b1;
                end
                WAIT_MOVE: begin
                    if (bus.move_valid && move_legal) begin
                        place_col   <= bus.move_col;
                        place_valid <= 1'b1;
                        timer_start <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= PLACE;
                    end else begin
                        if (bus.move_valid) move_reject <= 1'b1;
                        if (bus.time_out) begin
                            timeout_cnt <= cnt_inc;
                            timer_start <= 1'b0;
                            // Draw-by-timeouts takes precedence over any auto placement.
                            if (cnt_inc == TO_W'(MAX_TIMEOUTS)) begin
                                winner      <= W_DRAW;
                                game_over   <= 1'b1;
                                timer_clear <= 1'b1;
                                state       <= OVER;
                            end
`ifdef AUTO_MOVE_EN
                            else if (any_free) begin
                                place_col   <= free_idx;
                                place_valid <= 1'b1;
                                state       <= PLACE;
                            end
`endif
                            else begin
                                state <= SWITCH;
                            end
                        end
                    end
                end
                PLACE: begin
                    if (bus.board_done) begin
                        place_valid <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.win) begin
                        winner      <= winner_code(current_player);
                        game_over   <= 1'b1;
                        timer_clear <= 1'b1;
                        state       <= OVER;
                    end else if (bus.board_full) begin
                        winner      <= W_DRAW;
                        game_over   <= 1'b1;
                        timer_clear <= 1'b1;
                        state       <= OVER;
                    end else begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    current_player <= ~current_player;
                    timer_clear    <= 1'b1;
                    state          <= ARM;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.timer_start    = timer_start;
    assign bus.timer_clear    = timer_clear;
    assign bus.place_valid    = place_valid;
    assign bus.place_col      = place_col;
    assign bus.current_player = current_player;
    assign bus.move_reject    = move_reject;
    assign bus.game_over      = game_over;
    assign bus.winner         = winner;

endmodule

// File: tb/tb_turn_controller.sv
// Directed self-checking bench for turn_controller (default build and AUTO_MOVE_EN build).
module tb_turn_controller;
    import game_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    turn_controller_if #(.NUM_COLS(7), .COL_W(3)) bus ();

    turn_controller #(.NUM_COLS(7), .COL_W(3), .MAX_TIMEOUTS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a full placement handshake from PLACE back to WAIT_MOVE with no result.
    task automatic finish_turn();
        bus.board_done = 1'b1;
        step(1);
        bus.board_done = 1'b0;
        step(3);
    endtask

    task automatic timeout_round(input bit first);
        bus.time_out = 1'b1;
        step(1);
        bus.time_out = 1'b0;
`ifdef AUTO_MOVE_EN
        if (first) begin
            check_output("auto_place_valid", bus.place_valid, 1'b1);
            check_output("auto_place_col", bus.place_col, 3'd2);
        end
        finish_turn();
`else
        if (first) check_output("to_no_place", bus.place_valid, 1'b0);
        step(2);
`endif
    endtask

    task automatic play_move(input logic [2:0] col);
        bus.move_valid = 1'b1;
        bus.move_col   = col;
        step(1);
        bus.move_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start_game = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_col   = '0;
        bus.col_full   = '0;
        bus.board_done = 1'b0;
        bus.win        = 1'b0;
        bus.board_full = 1'b0;
        bus.time_out   = 1'b0;
        step(2);

        check_output("rst_timer_clear", bus.timer_clear, 1'b1);
        check_output("rst_timer_start", bus.timer_start, 1'b0);
        check_output("rst_place_valid", bus.place_valid, 1'b0);
        check_output("rst_game_over", bus.game_over, 1'b0);
        check_output("rst_winner", bus.winner, W_NONE);
        rst = 1'b1;
        step(1);

        $display("[TB] first legal move and turn switch");
        bus.start_game = 1'b1;
        step(1);
        bus.start_game = 1'b0;
        check_output("arm_clear", bus.timer_clear, 1'b1);
        check_output("arm_start", bus.timer_start, 1'b0);
        step(1);
        check_output("wait_start", bus.timer_start, 1'b1);
        check_output("wait_clear", bus.timer_clear, 1'b0);
        play_move(3'd3);
        check_output("place_valid", bus.place_valid, 1'b1);
        check_output("place_col3", bus.place_col, 3'd3);
        step(1);
        check_output("place_hold", bus.place_valid, 1'b1);
        bus.board_done = 1'b1;
        step(1);
        bus.board_done = 1'b0;
        check_output("check_drop", bus.place_valid, 1'b0);
        step(2);
        check_output("arm_p2", bus.current_player, P2);
        check_output("arm_clear_pulse", bus.timer_clear, 1'b1);
        step(1);
        check_output("clear_released", bus.timer_clear, 1'b0);
        check_output("p2_wait_start", bus.timer_start, 1'b1);

        $display("[TB] illegal moves");
        play_move(3'd7);
        check_output("rej_col7", bus.move_reject, 1'b1);
        check_output("rej_col7_timer", bus.timer_start, 1'b1);
        step(1);
        check_output("rej_col7_once", bus.move_reject, 1'b0);
        bus.col_full = 7'b0000100;
        play_move(3'd2);
        check_output("rej_full2", bus.move_reject, 1'b1);
        bus.start_game = 1'b1;
        step(1);
        bus.start_game = 1'b0;
        check_output("rej_full2_once", bus.move_reject, 1'b0);
        check_output("rej_no_place", bus.place_valid, 1'b0);
        check_output("start_ignored_player", bus.current_player, P2);
        check_output("start_ignored_timer", bus.timer_start, 1'b1);
        bus.col_full = '0;

        $display("[TB] reset mid-placement");
        play_move(3'd5);
        check_output("pre_rst_place", bus.place_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_output("async_place_valid", bus.place_valid, 1'b0);
        check_output("async_timer_clear", bus.timer_clear, 1'b1);
        check_output("async_player", bus.current_player, P1);
        check_output("async_place_col", bus.place_col, 3'd0);
        step(1);
        rst = 1'b1;
        step(1);
        check_output("post_rst_state", 8'(dut.state), 8'(IDLE));
        check_output("post_rst_clear", bus.timer_clear, 1'b1);

        $display("[TB] move and timeout in the same cycle");
        bus.start_game = 1'b1;
        step(1);
        bus.start_game = 1'b0;
        step(1);
        timeout_round(1'b0);
        check_output("cnt_after_to", 8'(dut.timeout_cnt), 8'd1);
        bus.time_out = 1'b1;
        play_move(3'd0);
        bus.time_out = 1'b0;
        check_output("race_place_col", bus.place_col, 3'd0);
        check_output("race_place_valid", bus.place_valid, 1'b1);
        check_output("race_cnt", 8'(dut.timeout_cnt), 8'd0);
        finish_turn();
        check_output("race_player", bus.current_player, P1);

        $display("[TB] three consecutive timeouts");
        bus.col_full = 7'b0000011;
        timeout_round(1'b1);
        timeout_round(1'b0);
        bus.time_out = 1'b1;
        step(1);
        bus.time_out = 1'b0;
        check_output("to_game_over", bus.game_over, 1'b1);
        check_output("to_winner", bus.winner, W_DRAW);
        check_output("to_timer_clear", bus.timer_clear, 1'b1);
        bus.col_full = '0;

        $display("[TB] P2 wins with board full");
        bus.start_game = 1'b1;
        step(1);
        bus.start_game = 1'b0;
        check_output("restart_over", bus.game_over, 1'b0);
        check_output("restart_winner", bus.winner, W_NONE);
        check_output("restart_player", bus.current_player, P1);
        step(1);
        play_move(3'd1);
        finish_turn();
        play_move(3'd4);
        bus.board_done = 1'b1;
        step(1);
        bus.board_done = 1'b0;
        bus.win        = 1'b1;
        bus.board_full = 1'b1;
        step(1);
        bus.win        = 1'b0;
        bus.board_full = 1'b0;
        check_output("p2_win_winner", bus.winner, W_P2);
        check_output("p2_win_over", bus.game_over, 1'b1);
        bus.start_game = 1'b1;
        step(1);
        bus.start_game = 1'b0;
        check_output("p2_restart_player", bus.current_player, P1);
        check_output("p2_restart_winner", bus.winner, W_NONE);

        $display("[TB] P1 win and full-board draw");
        step(1);
        play_move(3'd6);
        bus.board_done = 1'b1;
        step(1);
        bus.board_done = 1'b0;
        bus.win = 1'b1;
        step(1);
        bus.win = 1'b0;
        check_output("p1_win_winner", bus.winner, W_P1);
        bus.start_game = 1'b1;
        step(1);
        bus.start_game = 1'b0;
        step(1);
        play_move(3'd2);
        bus.board_done = 1'b1;
        step(1);
        bus.board_done = 1'b0;
        bus.board_full = 1'b1;
        step(1);
        bus.board_full = 1'b0;
        check_output("full_draw_winner", bus.winner, W_DRAW);
        check_output("full_draw_over", bus.game_over, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
